// File: rtl/lzss_dec_unpack_pkg.sv
// Shared helpers and state encoding for the LZSS decoder bit unpacker.
// The code-width helper is shared with lzss_dec_top so both sides agree on code width.
package lzss_dec_unpack_pkg;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // One flag bit plus the wider of a literal or an (offset, length) pair.
    function automatic int get_code_width(input int data_w, input int ref_size, input int coding_size);
        int match_w;
        match_w = clog2(ref_size) + clog2(coding_size);
        return 1 + ((data_w > match_w) ? data_w : match_w);
    endfunction

    localparam logic ST_RUN_ENC   = 1'b0;
    localparam logic ST_DRAIN_ENC = 1'b1;

    typedef enum logic {
        ST_RUN   = ST_RUN_ENC,
        ST_DRAIN = ST_DRAIN_ENC
    } state_e;

endpackage

// File: rtl/lzss_bit_accum.sv
// LSB-first bit accumulator: shifts out one code per pop and ORs new words in
// above the remaining bits, masking the unused tail of the last word.
module lzss_bit_accum
    import lzss_dec_unpack_pkg::*;
#(
    parameter int pWordWidth  = 32,
    parameter int pCodeWidth  = 10,
    parameter int pAccWidth   = pWordWidth + 2*pCodeWidth,
    parameter int pCntWidth   = clog2(pAccWidth + 1),
    parameter int pNbitsWidth = clog2(pWordWidth) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   shift_en,
    input  logic                   insert_en,
    input  logic [pWordWidth-1:0]  word,
    input  logic [pNbitsWidth-1:0] nbits,
    input  logic                   last,
    output logic [pCodeWidth-1:0]  code,
    output logic [pCntWidth-1:0]   count
);

    logic [pAccWidth-1:0]  acc_q;
    logic [pAccWidth-1:0]  acc_shifted;
    logic [pAccWidth-1:0]  acc_d;
    logic [pCntWidth-1:0]  count_q;
    logic [pCntWidth-1:0]  cnt_shifted;
    logic [pCntWidth-1:0]  cnt_d;
    logic [pCntWidth-1:0]  ins_bits;
    logic [pWordWidth-1:0] mask;
    logic [pWordWidth-1:0] word_masked;

    // Bits above count must stay zero, otherwise the OR-insert would corrupt data.
    always_comb begin
        mask = '0;
        for (int i = 0; i < pWordWidth; i++) begin
            mask[i] = !last || (pNbitsWidth'(i) < nbits);
        end
    end

    assign word_masked = word & mask;
    assign ins_bits    = last ? pCntWidth'(nbits) : pCntWidth'(pWordWidth);

    always_comb begin
        acc_shifted = acc_q;
        cnt_shifted = count_q;
        if (shift_en) begin
            acc_shifted = acc_q >> pCodeWidth;
            cnt_shifted = count_q - pCntWidth'(pCodeWidth);
        end
        acc_d = acc_shifted;
        cnt_d = cnt_shifted;
        if (insert_en) begin
            acc_d = acc_shifted | (pAccWidth'(word_masked) << cnt_shifted);
            cnt_d = cnt_shifted + ins_bits;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc_q   <= '0;
            count_q <= '0;
        end else begin
            acc_q   <= acc_d;
            count_q <= cnt_d;
        end
    end

    assign code  = acc_q[pCodeWidth-1:0];
    assign count = count_q;

endmodule

// File: rtl/lzss_dec_unpack.sv
// Unpacks a packed LSB-first word stream into fixed-width LZSS codes for lzss_dec_top.
//   state    | meaning
//   ST_RUN   | accepting words; one code held back until more bits or last arrive
//   ST_DRAIN | last word taken; emit remaining whole codes, then drop residual bits
module lzss_dec_unpack
    import lzss_dec_unpack_pkg::*;
#(
    parameter int pDataWidth     = 8,
    parameter int pReferenceSize = 64,
    parameter int pCodingSize    = 5,
    parameter int pCodeWidth     = get_code_width(pDataWidth, pReferenceSize, pCodingSize),
    parameter int pWordWidth     = 32,
    localparam int pAccWidth     = pWordWidth + 2*pCodeWidth,
    localparam int pCntWidth     = clog2(pAccWidth + 1),
    localparam int pNbitsWidth   = clog2(pWordWidth) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    output logic                   ow_ready,
    input  logic [pWordWidth-1:0]  i_word,
    input  logic [pNbitsWidth-1:0] i_nbits,
    input  logic                   i_last,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [pCodeWidth-1:0]  o_code,
    output logic                   o_last,
    output logic                   o_empty
);

    localparam logic [pCntWidth-1:0] IN_LIMIT = pCntWidth'(pAccWidth - pWordWidth);
    localparam logic [pCntWidth-1:0] CODE_1X  = pCntWidth'(pCodeWidth);
    localparam logic [pCntWidth-1:0] CODE_2X  = pCntWidth'(2*pCodeWidth);

    state_e               state_q;
    state_e               state_d;
    logic                 emitted_q;
    logic                 drain_done;
    logic                 in_fire;
    logic                 out_fire;
    logic [pCntWidth-1:0] count;

    assign in_fire  = i_valid && ow_ready;
    assign out_fire = o_valid && i_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            emitted_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (drain_done) begin
                emitted_q <= 1'b0;
            end else if (out_fire) begin
                emitted_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ow_ready   = 1'b0;
        o_valid    = 1'b0;
        o_last     = 1'b0;
        o_empty    = 1'b0;
        drain_done = 1'b0;
        case (state_q)
            ST_RUN: begin
                ow_ready = (count <= IN_LIMIT);
                o_valid  = (count >= CODE_2X);
                if (i_valid && ow_ready && i_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                o_valid = (count >= CODE_1X);
                o_last  = o_valid && (count < CODE_2X);
                // Fewer than one code left: residual is padding.
                if (!o_valid) begin
                    drain_done = 1'b1;
                    o_empty    = !emitted_q;
                    state_d    = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    lzss_bit_accum #(
        .pWordWidth (pWordWidth),
        .pCodeWidth (pCodeWidth),
        .pAccWidth  (pAccWidth),
        .pCntWidth  (pCntWidth),
        .pNbitsWidth(pNbitsWidth)
    ) u_accum (
        .clk      (clk),
        .rst      (rst),
        .clear    (drain_done),
        .shift_en (out_fire),
        .insert_en(in_fire),
        .word     (i_word),
        .nbits    (i_nbits),
        .last     (i_last),
        .code     (o_code),
        .count    (count)
    );

endmodule
